alu_rs_array: RTL and testbench
===============================

# alu_rs_array

Parametrised multi-entry ALU reservation station with an integrated ALU stage.
- Accepts dispatched operations whose operands are either values or producer tags, and snoops the common data bus (CDB) to resolve pending tags.
- Issues ready entries to a 4-op ALU and broadcasts each result with the entry's own tag on the CDB through a request/acknowledge handshake.
- Sits between the dispatch/rename stage and the CDB arbiter; supersedes the single-entry station.

## Interface
Parameters:
- DATA_W, 4: operand/result width.
- TAG_W, 4: tag width; TAG_W <= DATA_W.
- DEPTH, 4: number of entries, 2..8.
- BASE_TAG, 8: entry i owns tag BASE_TAG+i; BASE_TAG+DEPTH-1 must fit in TAG_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one FREE entry.
- disp_op  in  2  ALU op.
- disp_a / disp_b  in  DATA_W  operand value, or producer tag in bits [TAG_W-1:0].
- disp_a_valid / disp_b_valid  in  1  1 = operand is a value, 0 = operand is a tag.
- disp_tag  out  TAG_W  tag allocated to the next accepted dispatch.
- cdb_in_valid  in  1  CDB broadcast valid.
- cdb_in_tag  in  TAG_W  broadcast tag.
- cdb_in_data  in  DATA_W  broadcast value.
- cdb_out_req  out  1  result pending on CDB.
- cdb_out_tag  out  TAG_W  result tag.
- cdb_out_data  out  DATA_W  result value.
- cdb_out_ack  in  1  arbiter accepted the result.
- occupancy  out  $clog2(DEPTH+1)  count of non-FREE entries.

## Operation
- Entry states:
  - FREE
  - WAIT: at least one operand holds a tag.
  - READY
  - ISSUED: result in the output register, awaiting ack.
- Dispatch is accepted when disp_valid && disp_ready && !rst.
  - The lowest-index FREE entry is allocated; disp_tag = BASE_TAG + that index (combinational from registered state).
  - The entry becomes READY if both operands are valid, else WAIT.
- Snoop: when cdb_in_valid is high, every WAIT operand whose stored tag equals cdb_in_tag captures cdb_in_data at the edge. An entry with both operands valid moves WAIT->READY.
- Issue happens when the output register is empty, or is being acked this cycle.
  - Round-robin search starting at rr_ptr selects one READY entry.
  - The ALU result and BASE_TAG+index load into the output register; the entry moves to ISSUED; rr_ptr becomes index+1 mod DEPTH.
- ALU ops, all results mod 2^DATA_W:
  - 00: a+b
  - 01: a-b
  - 10: a&b
  - 11: a^b
- Ack: cdb_out_ack while cdb_out_req is high frees the ISSUED entry at that edge and clears cdb_out_req, unless a new issue loads the register in the same cycle (back-to-back). cdb_out_ack while cdb_out_req is low is ignored.
- An entry freed by ack is not offered by disp_ready until the following cycle.
- cdb_out_tag and cdb_out_data hold stable while cdb_out_req is high.
- The station does not snoop its own output internally; it relies on the external CDB returning the accepted result on cdb_in.

## Timing
- Reset (rst high at an edge):
  - all entries FREE, rr_ptr=0, cdb_out_req=0, cdb_out_tag=0, cdb_out_data=0, occupancy=0.
  - disp_ready=1 and disp_tag=BASE_TAG from the cycle after reset.
  - Reset mid-operation discards all entries and any pending result.
- Minimum latency, dispatch with both operands valid:
  - dispatch accepted at edge t;
  - entry READY in cycle t+1, issued at edge t+1;
  - cdb_out_req high in cycle t+2.
- Snoop latency: capture at edge t; eligible to issue in cycle t+1; cdb_out_req high in cycle t+2.
- Throughput: one result per cycle when the arbiter acks every cycle and READY entries exist.
- Full: disp_ready=0 when all DEPTH entries are non-FREE; disp_valid is then ignored.
- Simultaneous dispatch + ack: both take effect; occupancy is unchanged.
- A broadcast that matches both operands of one entry fills both in the same cycle.

## Configuration
- ALU_RS_DISPATCH_BYPASS_EN defined:
  - a dispatched tag operand equal to cdb_in_tag while cdb_in_valid is high in the same cycle captures cdb_in_data directly;
  - the entry becomes READY if its other operand is valid.
- Not defined:
  - that operand is stored as waiting and misses the broadcast;
  - the dispatcher must not dispatch a tag that is being broadcast in the same cycle.

## Test plan
- Reset, then dispatch op=00 a=3 b=4, both valid, DEPTH=4, BASE_TAG=8:
  - disp_tag=8;
  - cdb_out_req=1 two cycles later with tag 8, data 7;
  - ack -> req=0, occupancy=0.
- Dispatch op=01 a=2 b=5:
  - result data 13 (wrap mod 16).
- Dispatch a=tag 3 (invalid), b=1 valid; hold ack low; broadcast tag 3 data 6:
  - req rises two cycles after the broadcast with data 7.
- Dispatch 4 ops without ack:
  - disp_ready=0 and occupancy=4;
  - a 5th disp_valid is ignored;
  - one ack -> disp_ready=1 the next cycle with disp_tag equal to the freed tag.
- Dispatch with tag 5 while broadcasting tag 5 data 9 in the same cycle:
  - with the macro, the entry issues with 9;
  - without it, the entry stays WAIT and occupancy stays 1.
- Assert rst while cdb_out_req=1 and 3 entries are busy:
  - next cycle req=0, occupancy=0, disp_tag=8.

Source files
------------

// File: rtl/alu_rs_array.sv
// alu_rs_array: multi-entry ALU reservation station with CDB snoop, round-robin issue and a
// req/ack result register. Rev 1.0. Optional macro: ALU_RS_DISPATCH_BYPASS_EN.
`default_nettype none

module alu_rs_array #(
  parameter int DATA_W   = 4,
  parameter int TAG_W    = 4,
  parameter int DEPTH    = 4,
  parameter int BASE_TAG = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [1:0]                 disp_op,
  input  logic [DATA_W-1:0]          disp_a,
  input  logic [DATA_W-1:0]          disp_b,
  input  logic                       disp_a_valid,
  input  logic                       disp_b_valid,
  output logic [TAG_W-1:0]           disp_tag,
  input  logic                       cdb_in_valid,
  input  logic [TAG_W-1:0]           cdb_in_tag,
  input  logic [DATA_W-1:0]          cdb_in_data,
  output logic                       cdb_out_req,
  output logic [TAG_W-1:0]           cdb_out_tag,
  output logic [DATA_W-1:0]          cdb_out_data,
  input  logic                       cdb_out_ack,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [1:0] S_ISSUED = 2'd3;
  localparam logic [TAG_W-1:0] C_BASE_TAG = TAG_W'(BASE_TAG);

  logic [1:0]        r_state [DEPTH];
  logic [1:0]        r_op    [DEPTH];
  logic [DATA_W-1:0] r_a     [DEPTH];
  logic [DATA_W-1:0] r_b     [DEPTH];
  logic [DEPTH-1:0]  r_av;
  logic [DEPTH-1:0]  r_bv;
  logic [IDX_W-1:0]  r_rr;
  logic [IDX_W-1:0]  r_oidx;
  logic              r_req;
  logic [TAG_W-1:0]  r_otag;
  logic [DATA_W-1:0] r_odata;

  logic              w_free_found;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_iss_found;
  logic [IDX_W-1:0]  w_iss_idx;
  logic [IDX_W-1:0]  w_j;
  logic [DEPTH-1:0]  w_hit_a;
  logic [DEPTH-1:0]  w_hit_b;
  logic [OCC_W-1:0]  w_occ;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_da;
  logic [DATA_W-1:0] w_db;
  logic              w_dav;
  logic              w_dbv;
  logic              w_byp_a;
  logic              w_byp_b;
  logic              w_disp;
  logic              w_ack;
  logic              w_issue;

  // Lowest-index free entry wins allocation; scanning downward leaves the lowest match last.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (r_state[i] == S_FREE) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_occ   = '0;
    w_hit_a = '0;
    w_hit_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_state[i] != S_FREE) w_occ = w_occ + 1'b1;
      w_hit_a[i] = cdb_in_valid && (r_state[i] == S_WAIT) && !r_av[i] &&
                   (r_a[i][TAG_W-1:0] == cdb_in_tag);
      w_hit_b[i] = cdb_in_valid && (r_state[i] == S_WAIT) && !r_bv[i] &&
                   (r_b[i][TAG_W-1:0] == cdb_in_tag);
    end
  end

  always_comb begin
    w_iss_found = 1'b0;
    w_iss_idx   = '0;
    w_j         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_j = IDX_W'((int'(r_rr) + k) % DEPTH);
      if (!w_iss_found && (r_state[w_j] == S_READY)) begin
        w_iss_found = 1'b1;
        w_iss_idx   = w_j;
      end
    end
  end

  always_comb begin
    case (r_op[w_iss_idx])
      2'b00:   w_alu = r_a[w_iss_idx] + r_b[w_iss_idx];
      2'b01:   w_alu = r_a[w_iss_idx] - r_b[w_iss_idx];
      2'b10:   w_alu = r_a[w_iss_idx] & r_b[w_iss_idx];
      default: w_alu = r_a[w_iss_idx] ^ r_b[w_iss_idx];
    endcase
  end

`ifdef ALU_RS_DISPATCH_BYPASS_EN
  assign w_byp_a = cdb_in_valid && !disp_a_valid && (disp_a[TAG_W-1:0] == cdb_in_tag);
  assign w_byp_b = cdb_in_valid && !disp_b_valid && (disp_b[TAG_W-1:0] == cdb_in_tag);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign w_da    = w_byp_a ? cdb_in_data : disp_a;
  assign w_db    = w_byp_b ? cdb_in_data : disp_b;
  assign w_dav   = disp_a_valid | w_byp_a;
  assign w_dbv   = disp_b_valid | w_byp_b;
  assign w_disp  = disp_valid && w_free_found;
  assign w_ack   = r_req && cdb_out_ack;
  assign w_issue = w_iss_found && (!r_req || cdb_out_ack);

  // Snoop, dispatch, issue and ack touch entries in distinct states, so their writes never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= S_FREE;
        r_op[i]    <= '0;
        r_a[i]     <= '0;
        r_b[i]     <= '0;
      end
      r_av    <= '0;
      r_bv    <= '0;
      r_rr    <= '0;
      r_oidx  <= '0;
      r_req   <= 1'b0;
      r_otag  <= '0;
      r_odata <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit_a[i]) begin
          r_a[i]  <= cdb_in_data;
          r_av[i] <= 1'b1;
        end
        if (w_hit_b[i]) begin
          r_b[i]  <= cdb_in_data;
          r_bv[i] <= 1'b1;
        end
        if ((r_state[i] == S_WAIT) && (r_av[i] || w_hit_a[i]) && (r_bv[i] || w_hit_b[i]))
          r_state[i] <= S_READY;
      end
      if (w_disp) begin
        r_state[w_free_idx] <= (w_dav && w_dbv) ? S_READY : S_WAIT;
        r_op[w_free_idx]    <= disp_op;
        r_a[w_free_idx]     <= w_da;
        r_b[w_free_idx]     <= w_db;
        r_av[w_free_idx]    <= w_dav;
        r_bv[w_free_idx]    <= w_dbv;
      end
      if (w_ack) r_state[r_oidx] <= S_FREE;
      if (w_issue) begin
        r_state[w_iss_idx] <= S_ISSUED;
        r_req              <= 1'b1;
        r_otag             <= C_BASE_TAG + TAG_W'(w_iss_idx);
        r_odata            <= w_alu;
        r_oidx             <= w_iss_idx;
        r_rr               <= (w_iss_idx == IDX_W'(DEPTH-1)) ? '0 : w_iss_idx + 1'b1;
      end else if (w_ack) begin
        r_req <= 1'b0;
      end
    end
  end

  assign disp_ready   = w_free_found;
  assign disp_tag     = C_BASE_TAG + TAG_W'(w_free_idx);
  assign cdb_out_req  = r_req;
  assign cdb_out_tag  = r_otag;
  assign cdb_out_data = r_odata;
  assign occupancy    = w_occ;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs_array.sv
// tb_alu_rs_array: directed scenarios plus randomized traffic scored against a tag-level model.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_rs_array;
  localparam int DATA_W   = 4;
  localparam int TAG_W    = 4;
  localparam int DEPTH    = 4;
  localparam int BASE_TAG = 8;
  localparam int OCC_W    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_valid;
  logic              disp_ready;
  logic [1:0]        disp_op;
  logic [DATA_W-1:0] disp_a;
  logic [DATA_W-1:0] disp_b;
  logic              disp_a_valid;
  logic              disp_b_valid;
  logic [TAG_W-1:0]  disp_tag;
  logic              cdb_in_valid;
  logic [TAG_W-1:0]  cdb_in_tag;
  logic [DATA_W-1:0] cdb_in_data;
  logic              cdb_out_req;
  logic [TAG_W-1:0]  cdb_out_tag;
  logic [DATA_W-1:0] cdb_out_data;
  logic              cdb_out_ack;
  logic [OCC_W-1:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which owned tags are outstanding and what each must produce.
  bit         busy [DEPTH];
  logic [3:0] expv [DEPTH];
  logic [3:0] pv   [8];

  alu_rs_array #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .BASE_TAG(BASE_TAG)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a(disp_a), .disp_b(disp_b),
    .disp_a_valid(disp_a_valid), .disp_b_valid(disp_b_valid), .disp_tag(disp_tag),
    .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_data(cdb_in_data),
    .cdb_out_req(cdb_out_req), .cdb_out_tag(cdb_out_tag), .cdb_out_data(cdb_out_data),
    .cdb_out_ack(cdb_out_ack), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid   = 1'b0;
    disp_op      = 2'd0;
    disp_a       = '0;
    disp_b       = '0;
    disp_a_valid = 1'b1;
    disp_b_valid = 1'b1;
    cdb_in_valid = 1'b0;
    cdb_in_tag   = '0;
    cdb_in_data  = '0;
    cdb_out_ack  = 1'b0;
  endtask

  task automatic set_disp(input logic [1:0] op, input logic [3:0] a, input logic av,
                          input logic [3:0] b, input logic bv);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_a       = a;
    disp_a_valid = av;
    disp_b       = b;
    disp_b_valid = bv;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (busy[i]) n++;
    return n;
  endfunction

  // One randomized cycle: check visible state against the model, drive inputs, advance the model.
  task automatic rnd_cycle(input bit allow_disp, input bit force_ack);
    int         lo;
    logic [1:0] oi;
    logic [1:0] op;
    logic       av, bv;
    logic [3:0] a, b, bt;
    bit         dv, bc, do_ack, acked;
    lo = -1;
    for (int i = DEPTH-1; i >= 0; i--) if (!busy[i]) lo = i;
    chk("rnd_ready", 32'(disp_ready), 32'(lo >= 0));
    if (lo >= 0) chk("rnd_disp_tag", 32'(disp_tag), 32'(BASE_TAG + lo));
    chk("rnd_occupancy", 32'(occupancy), 32'(model_count()));

    do_ack = force_ack || ($urandom_range(0, 9) < 7);
    cdb_out_ack = do_ack;
    acked = 1'b0;
    oi = '0;
    if (cdb_out_req === 1'b1) begin
      if (cdb_out_tag >= 4'(BASE_TAG) && cdb_out_tag < 4'(BASE_TAG + DEPTH)) begin
        oi = 2'(cdb_out_tag - 4'(BASE_TAG));
        chk("rnd_out_busy", 32'(busy[oi]), 32'(1));
        chk("rnd_out_data", 32'(cdb_out_data), 32'(expv[oi]));
        acked = do_ack;
      end else begin
        chk("rnd_out_tag_range", 32'(cdb_out_tag), 32'(BASE_TAG));
      end
    end

    dv = allow_disp && ($urandom_range(0, 9) < 6);
    op = 2'($urandom_range(0, 3));
    av = 1'($urandom_range(0, 1));
    bv = 1'($urandom_range(0, 1));
    a  = av ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
    b  = bv ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
    if (dv) set_disp(op, a, av, b, bv);
    else disp_valid = 1'b0;

    bc = 1'($urandom_range(0, 1));
    bt = 4'($urandom_range(0, 7));
    if (dv && ((!av && a == bt) || (!bv && b == bt))) bc = 1'b0;
    cdb_in_valid = bc;
    cdb_in_tag   = bt;
    cdb_in_data  = pv[bt[2:0]];

    if (dv && lo >= 0) begin
      busy[2'(lo)] = 1'b1;
      expv[2'(lo)] = alu(op, av ? a : pv[a[2:0]], bv ? b : pv[b[2:0]]);
    end
    if (acked) busy[oi] = 1'b0;
    tick();
  endtask

  initial begin
    idle();
    for (int i = 0; i < DEPTH; i++) begin busy[i] = 1'b0; expv[i] = '0; end
    for (int i = 0; i < 8; i++) pv[i] = 4'($urandom_range(0, 15));

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req", 32'(cdb_out_req), 32'(0));
    chk("rst_occ", 32'(occupancy), 32'(0));
    chk("rst_out_tag", 32'(cdb_out_tag), 32'(0));
    chk("rst_out_data", 32'(cdb_out_data), 32'(0));
    chk("rst_ready", 32'(disp_ready), 32'(1));
    chk("rst_disp_tag", 32'(disp_tag), 32'(8));
    rst = 1'b0;

    // 3 + 4 with minimum latency
    set_disp(2'd0, 4'd3, 1'b1, 4'd4, 1'b1);
    chk("add_disp_tag", 32'(disp_tag), 32'(8));
    tick();
    disp_valid = 1'b0;
    chk("add_req_t1", 32'(cdb_out_req), 32'(0));
    chk("add_occ_t1", 32'(occupancy), 32'(1));
    tick();
    chk("add_req_t2", 32'(cdb_out_req), 32'(1));
    chk("add_tag", 32'(cdb_out_tag), 32'(8));
    chk("add_data", 32'(cdb_out_data), 32'(7));
    cdb_out_ack = 1'b1;
    tick();
    cdb_out_ack = 1'b0;
    chk("add_ack_req", 32'(cdb_out_req), 32'(0));
    chk("add_ack_occ", 32'(occupancy), 32'(0));

    // 2 - 5 wraps to 13
    set_disp(2'd1, 4'd2, 1'b1, 4'd5, 1'b1);
    tick();
    disp_valid = 1'b0;
    tick();
    chk("sub_req", 32'(cdb_out_req), 32'(1));
    chk("sub_data", 32'(cdb_out_data), 32'(13));
    cdb_out_ack = 1'b1;
    tick();
    cdb_out_ack = 1'b0;

    // Tag operand resolved by a later broadcast
    set_disp(2'd0, 4'd3, 1'b0, 4'd1, 1'b1);
    tick();
    disp_valid = 1'b0;
    tick();
    chk("snoop_wait_req", 32'(cdb_out_req), 32'(0));
    cdb_in_valid = 1'b1; cdb_in_tag = 4'd3; cdb_in_data = 4'd6;
    tick();
    cdb_in_valid = 1'b0;
    chk("snoop_req_t1", 32'(cdb_out_req), 32'(0));
    tick();
    chk("snoop_req_t2", 32'(cdb_out_req), 32'(1));
    chk("snoop_data", 32'(cdb_out_data), 32'(7));
    cdb_out_ack = 1'b1;
    tick();
    cdb_out_ack = 1'b0;

    // Fill all entries, then free one with an ack
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(2'd2, 4'(i + 1), 1'b1, 4'd15, 1'b1);
      tick();
    end
    chk("full_ready", 32'(disp_ready), 32'(0));
    chk("full_occ", 32'(occupancy), 32'(4));
    tick();
    disp_valid = 1'b0;
    chk("full_ignored_occ", 32'(occupancy), 32'(4));
    chk("full_out_tag", 32'(cdb_out_tag), 32'(8));
    cdb_out_ack = 1'b1;
    tick();
    cdb_out_ack = 1'b0;
    chk("full_freed_ready", 32'(disp_ready), 32'(1));
    chk("full_freed_tag", 32'(disp_tag), 32'(8));
    chk("full_freed_occ", 32'(occupancy), 32'(3));
    cdb_out_ack = 1'b1;
    repeat (6) tick();
    cdb_out_ack = 1'b0;
    chk("drain_occ", 32'(occupancy), 32'(0));
    chk("drain_req", 32'(cdb_out_req), 32'(0));

    // Dispatch a tag that is on the CDB in the same cycle
    set_disp(2'd0, 4'd5, 1'b0, 4'd0, 1'b1);
    cdb_in_valid = 1'b1; cdb_in_tag = 4'd5; cdb_in_data = 4'd9;
    tick();
    idle();
    tick();
`ifdef ALU_RS_DISPATCH_BYPASS_EN
    chk("bypass_req", 32'(cdb_out_req), 32'(1));
    chk("bypass_data", 32'(cdb_out_data), 32'(9));
`else
    chk("nobypass_req", 32'(cdb_out_req), 32'(0));
    chk("nobypass_occ", 32'(occupancy), 32'(1));
`endif

    // Reset with a pending result and three busy entries
    set_disp(2'd0, 4'd1, 1'b1, 4'd1, 1'b1);
    tick();
    tick();
    disp_valid = 1'b0;
    chk("prerst_occ", 32'(occupancy), 32'(3));
    chk("prerst_req", 32'(cdb_out_req), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req", 32'(cdb_out_req), 32'(0));
    chk("midrst_occ", 32'(occupancy), 32'(0));
    chk("midrst_disp_tag", 32'(disp_tag), 32'(8));

    // Randomized traffic, then drain
    for (int c = 0; c < 2000; c++) rnd_cycle(1'b1, 1'b0);
    for (int k = 0; k < 400; k++) begin
      if (model_count() == 0) break;
      rnd_cycle(1'b0, 1'b1);
    end
    idle();
    chk("rnd_final_occ", 32'(occupancy), 32'(0));
    chk("rnd_final_req", 32'(cdb_out_req), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
